// File: rtl/keystream_xor.sv
// keystream_xor: snapshots one keystream batch from the concatenator and XORs it byte by
// byte onto a valid/ready data stream. This is the ChaCha20 encrypt/decrypt datapath that
// feeds Poly1305.
// Optional build macro KEYSTREAM_XOR_LEN_COUNT_EN adds msg_len_o, a saturating 64-bit
// per-message byte count.
module keystream_xor #(
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned NUM_MATRICES = 2,
  parameter int unsigned NO_REG       = 64 * NUM_MATRICES
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ks_full_i,
  input  logic [DATA_SIZE-1:0] ks_data_i [NO_REG],
  output logic                 ks_req_o,
  input  logic                 pt_valid_i,
  input  logic [DATA_SIZE-1:0] pt_data_i,
  input  logic                 pt_last_i,
  output logic                 pt_ready_o,
  output logic                 ct_valid_o,
  output logic [DATA_SIZE-1:0] ct_data_o,
  output logic                 ct_last_o,
  input  logic                 ct_ready_i
`ifdef KEYSTREAM_XOR_LEN_COUNT_EN
  ,
  output logic [63:0]          msg_len_o
`endif
);

  localparam int unsigned IdxW = (NO_REG > 1) ? $clog2(NO_REG) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NO_REG - 1);

  typedef enum logic [1:0] {
    StReq,
    StWaitKs,
    StStream
  } state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_SIZE-1:0] ks_buf_q [NO_REG];
  logic                 ct_valid_q, ct_valid_d;
  logic [DATA_SIZE-1:0] ct_data_q, ct_data_d;
  logic                 ct_last_q, ct_last_d;
  logic                 pt_hs;
  logic                 ks_load;

  // Handshake and request decode; ks_req is masked while reset is held so it only
  // pulses once reset has been released.
  always_comb begin
    pt_ready_o = (state_q == StStream) && (!ct_valid_q || ct_ready_i);
    pt_hs      = pt_valid_i && pt_ready_o;
    ks_req_o   = (state_q == StReq) && !rst_i;
    ks_load    = (state_q == StWaitKs) && ks_full_i;
  end

  // Next-state and keystream index; exhaustion and message end share one return to StReq.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      StReq: begin
        state_d = StWaitKs;
      end
      StWaitKs: begin
        if (ks_full_i) begin
          state_d = StStream;
          idx_d   = '0;
        end
      end
      StStream: begin
        if (pt_hs) begin
          if (pt_last_i || (idx_q == IdxLast)) begin
            state_d = StReq;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StReq;
        idx_d   = '0;
      end
    endcase
  end

  // Single output register: loads on input accept, otherwise drains on ct_ready.
  always_comb begin
    ct_valid_d = ct_valid_q;
    ct_data_d  = ct_data_q;
    ct_last_d  = ct_last_q;
    if (pt_hs) begin
      ct_valid_d = 1'b1;
      ct_data_d  = pt_data_i ^ ks_buf_q[idx_q];
      ct_last_d  = pt_last_i;
    end else if (ct_ready_i) begin
      ct_valid_d = 1'b0;
    end
  end

  // Control and output state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StReq;
      idx_q      <= '0;
      ct_valid_q <= 1'b0;
      ct_data_q  <= '0;
      ct_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ct_valid_q <= ct_valid_d;
      ct_data_q  <= ct_data_d;
      ct_last_q  <= ct_last_d;
    end
  end

  // Keystream snapshot; contents only matter once StStream is entered, so no reset.
  always_ff @(posedge clk_i) begin
    if (ks_load) begin
      for (int unsigned i = 0; i < NO_REG; i++) begin
        ks_buf_q[i] <= ks_data_i[i];
      end
    end
  end

  assign ct_valid_o = ct_valid_q;
  assign ct_data_o  = ct_data_q;
  assign ct_last_o  = ct_last_q;

`ifdef KEYSTREAM_XOR_LEN_COUNT_EN
  logic [63:0] len_q, len_d;
  logic        new_msg_q, new_msg_d;

  // Byte count: first byte after a last (or after reset) reloads 1, otherwise saturating +1.
  always_comb begin
    len_d     = len_q;
    new_msg_d = new_msg_q;
    if (pt_hs) begin
      new_msg_d = pt_last_i;
      if (new_msg_q) begin
        len_d = 64'd1;
      end else if (len_q != '1) begin
        len_d = len_q + 64'd1;
      end
    end
  end

  // Length counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      len_q     <= '0;
      new_msg_q <= 1'b1;
    end else begin
      len_q     <= len_d;
      new_msg_q <= new_msg_d;
    end
  end

  assign msg_len_o = len_q;
`endif

endmodule

// File: tb/tb_keystream_xor.sv
// Directed bench for keystream_xor with an expected-output queue and an automatic
// keystream refill responder. Builds with or without KEYSTREAM_XOR_LEN_COUNT_EN.
module tb_keystream_xor;

  localparam int unsigned NoReg = 128;

  logic       clk = 1'b0;
  logic       rst;
  logic       ks_full;
  logic [7:0] ks_data [NoReg];
  logic       ks_req;
  logic       pt_valid;
  logic [7:0] pt_data;
  logic       pt_last;
  logic       pt_ready;
  logic       ct_valid;
  logic [7:0] ct_data;
  logic       ct_last;
  logic       ct_ready;
`ifdef KEYSTREAM_XOR_LEN_COUNT_EN
  logic [63:0] msg_len;
`endif

  int         checks = 0;
  int         failures = 0;
  logic [8:0] exp_q [$];
  logic [8:0] mon_e;
  logic [7:0] seed = 8'h00;
  int         fill_lat = 2;
  int         fill_pend = 0;
  int         spur_cnt = 0;
  int         spur_done = 0;
  int         req_pulses = 0;
  int         req_hi = 0;
  logic       req_prev = 1'b0;
  int         p;

  always #5 clk = ~clk;

  keystream_xor #(
    .DATA_SIZE   (8),
    .NUM_MATRICES(2),
    .NO_REG      (NoReg)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .ks_full_i (ks_full),
    .ks_data_i (ks_data),
    .ks_req_o  (ks_req),
    .pt_valid_i(pt_valid),
    .pt_data_i (pt_data),
    .pt_last_i (pt_last),
    .pt_ready_o(pt_ready),
    .ct_valid_o(ct_valid),
    .ct_data_o (ct_data),
    .ct_last_o (ct_last),
    .ct_ready_i(ct_ready)
`ifdef KEYSTREAM_XOR_LEN_COUNT_EN
    ,
    .msg_len_o (msg_len)
`endif
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Keystream byte for message position pos under the pattern ks_data[i] = i ^ seed.
  function automatic logic [7:0] ks_byte(input int pos);
    return 8'(pos % NoReg) ^ seed;
  endfunction

  // Refill responder: answers each ks_req with a ks_full pulse fill_lat cycles later;
  // also injects a stray ks_full with a different pattern when spur_cnt is bumped.
  initial begin
    ks_full = 1'b0;
    for (int i = 0; i < NoReg; i++) ks_data[i] = 8'(i);
    forever begin
      @(negedge clk);
      #3;
      ks_full = 1'b0;
      if (fill_pend > 0) begin
        fill_pend--;
        if (fill_pend == 0) begin
          for (int i = 0; i < NoReg; i++) ks_data[i] = 8'(i) ^ seed;
          ks_full = 1'b1;
        end
      end else if (ks_req) begin
        fill_pend = fill_lat;
      end
      if (spur_cnt != spur_done) begin
        spur_done = spur_cnt;
        for (int i = 0; i < NoReg; i++) ks_data[i] = 8'(i) ^ 8'hC3;
        ks_full = 1'b1;
      end
    end
  end

  // Output monitor and ks_req pulse accounting.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (ks_req) begin
        req_hi++;
        if (!req_prev) req_pulses++;
        chk("pt_ready_in_req", 64'(pt_ready), 64'(0));
      end
      req_prev = ks_req;
      if (ct_valid && ct_ready) begin
        if (exp_q.size() == 0) begin
          chk("ct_unexpected", 64'(ct_valid), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          chk("ct_data", 64'(ct_data), 64'(mon_e[7:0]));
          chk("ct_last", 64'(ct_last), 64'(mon_e[8]));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic l, input int pos);
    bit done = 1'b0;
    int budget = 0;
    pt_valid = 1'b1;
    pt_data  = d;
    pt_last  = l;
    while (!done && budget < 500) begin
      #1;
      if (pt_ready) begin
        exp_q.push_back({l, d ^ ks_byte(pos)});
        done = 1'b1;
      end
      @(negedge clk);
      budget++;
    end
    pt_valid = 1'b0;
    pt_last  = 1'b0;
    if (!done) chk("accept_timeout", 64'(done), 64'(1));
  endtask

  task automatic send_msg(input int n, input logic [7:0] base, input logic [7:0] step);
    for (int k = 0; k < n; k++) begin
      send_byte(8'(base + 8'(k) * step), (k == n - 1), k);
    end
  endtask

  task automatic drain(input string name);
    int budget = 0;
    while (exp_q.size() != 0 && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    repeat (6) @(negedge clk);
    chk(name, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst      = 1'b1;
    pt_valid = 1'b0;
    pt_data  = 8'h00;
    pt_last  = 1'b0;
    ct_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ks_req", 64'(ks_req), 64'(0));
    chk("rst_pt_ready", 64'(pt_ready), 64'(0));
    chk("rst_ct_valid", 64'(ct_valid), 64'(0));
    chk("rst_ct_data", 64'(ct_data), 64'(0));
    chk("rst_ct_last", 64'(ct_last), 64'(0));
`ifdef KEYSTREAM_XOR_LEN_COUNT_EN
    chk("rst_msg_len", msg_len, 64'(0));
`endif
    @(negedge clk);
    rst = 1'b0;

    // 4 x 0xFF against ks[i]=i -> FF FE FD FC; one request after reset, one after last.
    send_msg(4, 8'hFF, 8'h00);
    drain("t1_drain");
    chk("t1_req_pulses", 64'(req_pulses), 64'(2));

    // 130 zero bytes spanning a refill.
    p = req_pulses;
    send_msg(130, 8'h00, 8'h00);
    drain("t2_drain");
    chk("t2_req_pulses", 64'(req_pulses), 64'(p + 2));

    // Exactly one batch with last on its final byte: a single request.
    p = req_pulses;
    send_msg(128, 8'h5A, 8'h01);
    drain("t3_drain");
    chk("t3_req_pulses", 64'(req_pulses), 64'(p + 1));
    send_msg(1, 8'h33, 8'h00);
    drain("t3b_drain");

    // Backpressure: output held, input stalled, nothing lost on release.
    send_byte(8'h10, 1'b0, 0);
    ct_ready = 1'b0;
    pt_valid = 1'b1;
    pt_data  = 8'h21;
    pt_last  = 1'b0;
    repeat (5) begin
      #1;
      chk("bp_pt_ready", 64'(pt_ready), 64'(0));
      chk("bp_ct_valid", 64'(ct_valid), 64'(1));
      chk("bp_ct_data", 64'(ct_data), 64'(8'h10 ^ ks_byte(0)));
      @(negedge clk);
    end
    ct_ready = 1'b1;
    send_byte(8'h21, 1'b0, 1);
    for (int k = 2; k < 6; k++) send_byte(8'(8'h30 + k), (k == 5), k);
    drain("bp_drain");

    // Stray ks_full mid-stream must not replace the snapshot.
    send_byte(8'h40, 1'b0, 0);
    send_byte(8'h41, 1'b0, 1);
    spur_cnt++;
    for (int k = 2; k < 10; k++) send_byte(8'(8'h40 + k), (k == 9), k);
    drain("spur_drain");

    // Reset with a held output byte; then a fresh message on a new keystream pattern.
    send_byte(8'h77, 1'b0, 0);
    ct_ready = 1'b0;
    rst      = 1'b1;
    seed     = 8'h6C;
    exp_q.delete();
    @(negedge clk);
    #1;
    chk("rst2_ct_valid", 64'(ct_valid), 64'(0));
    chk("rst2_ks_req_held", 64'(ks_req), 64'(0));
    rst      = 1'b0;
    ct_ready = 1'b1;
    #1;
    chk("rst2_ks_req_pulse", 64'(ks_req), 64'(1));
    @(negedge clk);
`ifdef KEYSTREAM_XOR_LEN_COUNT_EN
    chk("rst2_msg_len", msg_len, 64'(0));
`endif
    send_msg(5, 8'h81, 8'h03);
    drain("t6_drain");
`ifdef KEYSTREAM_XOR_LEN_COUNT_EN
    chk("msg_len_5", msg_len, 64'(5));
`endif

    chk("ks_req_one_cycle", 64'(req_hi), 64'(req_pulses));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
